// File: rtl/key_pkg.sv
// Shared types and helpers for the key capture front-end and the 8:3 encoder.
// State encodings are fixed so encoder-side checks can decode them.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    localparam int ONEHOT_MAX_W = 32;

    // Narrower vectors are zero-extended by the caller; zero-extension does not change the one-hot property.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Each bit is synchronized on its own; the bus is not sampled coherently.
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/onehot_key_capture.sv
// Synchronizes and debounces raw key lines and presents a guaranteed one-hot vector.
// Multi-key patterns are rejected, and all keys must be released before the next key is accepted.
module onehot_key_capture
    import key_pkg::*;
#(
    parameter int N_IN            = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] key_raw,
    output logic [N_IN-1:0] onehot_out,
    output logic            onehot_valid,
    output logic            key_event,
    output logic            multi_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  sync;
    logic [N_IN-1:0]  cand;
    logic [CNT_W-1:0] cnt;
    logic             cand_onehot;
    key_state_t       state;

    sync2 #(
        .WIDTH(N_IN)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (key_raw),
        .q    (sync)
    );

    assign cand_onehot = is_onehot(ONEHOT_MAX_W'(cand));

    // The counter only advances while below CNT_MAX, so it saturates and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            onehot_out   <= '0;
            onehot_valid <= 1'b0;
            key_event    <= 1'b0;
            multi_err    <= 1'b0;
        end else begin
            key_event <= 1'b0;
            multi_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync != '0) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (sync == '0) begin
                        state <= IDLE;
                    end else if (sync != cand) begin
                        cand <= sync;
                        cnt  <= '0;
                    end else if (cnt < CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (cand_onehot) begin
                        onehot_out   <= cand;
                        onehot_valid <= 1'b1;
                        key_event    <= 1'b1;
                        state        <= HELD;
                    end else begin
                        // Restart the count so the release window is a full debounce period.
                        multi_err <= 1'b1;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end
                end
                HELD: begin
                    if (sync != onehot_out) begin
                        onehot_out   <= '0;
                        onehot_valid <= 1'b0;
                        cnt          <= '0;
                        state        <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (sync != '0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_key_capture.sv
// Directed bench for onehot_key_capture with DEBOUNCE_CYCLES=4.
// Stimulus pushes expected pulses with their cycle; a negedge monitor pops and compares them.
module tb_onehot_key_capture;
    import key_pkg::*;

    localparam int N_IN    = 8;
    localparam int DEB     = 4;
    localparam int LATENCY = DEB + 3;

    typedef struct {
        bit          isErr;
        logic [7:0]  onehot;
        int          cycle;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N_IN-1:0] key_raw;
    logic [N_IN-1:0] onehot_out;
    logic            onehot_valid;
    logic            key_event;
    logic            multi_err;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    onehot_key_capture #(
        .N_IN           (N_IN),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw     (key_raw),
        .onehot_out  (onehot_out),
        .onehot_valid(onehot_valid),
        .key_event   (key_event),
        .multi_err   (multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] idx = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 = no pulse expected, 1 = key_event, 2 = multi_err
    task automatic applyStimulus(input logic [7:0] val, input int kind);
        exp_t e;
        key_raw = val;
        if (kind != 0) begin
            e.isErr  = (kind == 2);
            e.onehot = (kind == 2) ? 8'h00 : val;
            e.cycle  = cycle + LATENCY;
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expOut, input logic expValid);
        checks++;
        if (onehot_out !== expOut || onehot_valid !== expValid) begin
            errors++;
            $display("[TB] FAIL %s: got out=%h valid=%b, want out=%h valid=%b (cycle %0d)",
                     name, onehot_out, onehot_valid, expOut, expValid, cycle);
        end
    endtask

    task automatic checkState(input string name, input key_state_t expState);
        checks++;
        if (dut.state !== expState) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d, want state=%0d (cycle %0d)",
                     name, dut.state, expState, cycle);
        end
    endtask

    // Monitor: invariants every cycle, and scoreboard compare on every pulse.
    always @(negedge clk) begin
        checks++;
        if ((onehot_valid && !is_onehot(ONEHOT_MAX_W'(onehot_out))) ||
            (!onehot_valid && onehot_out != 8'h00)) begin
            errors++;
            $display("[TB] FAIL invariant: got out=%h valid=%b (cycle %0d)", onehot_out, onehot_valid, cycle);
        end
        checks++;
        if (key_event && multi_err) begin
            errors++;
            $display("[TB] FAIL exclusive: key_event and multi_err both high (cycle %0d)", cycle);
        end
        if (key_event || multi_err) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected pulse: event=%b err=%b out=%h (cycle %0d)",
                         key_event, multi_err, onehot_out, cycle);
            end else begin
                monE = expQ.pop_front();
                if (monE.isErr != multi_err || monE.onehot != onehot_out || monE.cycle != cycle) begin
                    errors++;
                    $display("[TB] FAIL pulse: got err=%b out=%h cycle=%0d, want err=%b out=%h cycle=%0d",
                             multi_err, onehot_out, cycle, monE.isErr, monE.onehot, monE.cycle);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        rst_n   = 1'b1;
        key_raw = 8'h00;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_state", 8'h00, 1'b0);
        checks++;
        if (key_event !== 1'b0 || multi_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got event=%b err=%b, want 0 0", key_event, multi_err);
        end
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(3);

        $display("[TB] clean press");
        applyStimulus(8'h04, 1);
        waitCycles(LATENCY - 1);
        checkOutput("press_before", 8'h00, 1'b0);
        waitCycles(1);
        checkOutput("press_accept", 8'h04, 1'b1);
        waitCycles(13);
        checkOutput("press_hold", 8'h04, 1'b1);
        checks++;
        if (encode(onehot_out) !== 3'b010) begin
            errors++;
            $display("[TB] FAIL encoder: got %b, want 010", encode(onehot_out));
        end
        applyStimulus(8'h00, 0);
        waitCycles(2);
        checkOutput("release_before", 8'h04, 1'b1);
        waitCycles(1);
        checkOutput("release_drop", 8'h00, 1'b0);
        waitCycles(10);

        $display("[TB] bounce");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h10, 0);
            waitCycles(2);
            applyStimulus(8'h00, 0);
            waitCycles(2);
        end
        checkOutput("bounce_quiet", 8'h00, 1'b0);
        applyStimulus(8'h10, 1);
        waitCycles(LATENCY);
        checkOutput("bounce_accept", 8'h10, 1'b1);
        waitCycles(3);
        applyStimulus(8'h00, 0);
        waitCycles(12);

        $display("[TB] multi-key");
        applyStimulus(8'h41, 2);
        waitCycles(LATENCY);
        checkOutput("multi_novalid", 8'h00, 1'b0);
        applyStimulus(8'h00, 0);
        waitCycles(6);
        applyStimulus(8'h01, 1);
        waitCycles(LATENCY);
        checkOutput("multi_then_single", 8'h01, 1'b1);
        waitCycles(3);
        applyStimulus(8'h00, 0);
        waitCycles(12);

        $display("[TB] key added while held");
        applyStimulus(8'h02, 1);
        waitCycles(LATENCY + 1);
        checkOutput("added_held", 8'h02, 1'b1);
        applyStimulus(8'h0A, 0);
        waitCycles(2);
        checkOutput("added_before", 8'h02, 1'b1);
        waitCycles(1);
        checkOutput("added_drop", 8'h00, 1'b0);
        waitCycles(2);
        applyStimulus(8'h00, 0);
        waitCycles(8);
        applyStimulus(8'h08, 1);
        waitCycles(LATENCY);
        checkOutput("added_new_key", 8'h08, 1'b1);
        waitCycles(3);
        applyStimulus(8'h00, 0);
        waitCycles(12);

        $display("[TB] release glitch");
        applyStimulus(8'h20, 1);
        waitCycles(LATENCY + 3);
        applyStimulus(8'h00, 0);
        c = cycle;
        waitCycles(3);
        applyStimulus(8'h20, 0);
        waitCycles(1);
        applyStimulus(8'h00, 0);
        waitCycles(3);
        checkState("glitch_hold_a", RELEASE);
        waitCycles(2);
        checkState("glitch_hold_b", RELEASE);
        waitCycles(1);
        checkState("glitch_idle", IDLE);
        checks++;
        if (cycle - c != 10) begin
            errors++;
            $display("[TB] FAIL glitch_timing: got %0d cycles, want 10", cycle - c);
        end
        waitCycles(4);

        $display("[TB] reset mid-operation");
        applyStimulus(8'h04, 1);
        waitCycles(LATENCY + 2);
        checkOutput("reset_pre", 8'h04, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", 8'h00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(8'h04, 1);
        waitCycles(LATENCY - 1);
        checkOutput("reset_exit_quiet", 8'h00, 1'b0);
        waitCycles(1);
        checkOutput("reset_reaccept", 8'h04, 1'b1);
        waitCycles(2);
        applyStimulus(8'h00, 0);
        waitCycles(12);

        for (int i = 0; i < 50 && expQ.size() != 0; i++) waitCycles(1);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending: got %0d expected pulses never seen, want 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
